// File: rtl/cache_mem_bridge_pkg.sv
// Shared configuration for the cache line-transfer bridge: line geometry,
// address width, controller state encoding and address helpers.
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 16
`endif
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

package cache_mem_bridge_pkg;

  localparam int LINE_BYTES = `CACHE_LINE_SIZE;
  localparam int ADDR_W     = `MAX_BIT_POS + 1;
  localparam int BEATS      = LINE_BYTES / 4;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W     = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Clears the in-line offset bits; the line size is a power of two.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

  // Word address of beat idx; OR is safe because the base is line aligned,
  // so the offset can never carry into the line address.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] idx);
    return base | ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/cache_mem_bridge_line_word_mux.sv
// Selects one 32-bit word of a cache line by beat index (little-endian:
// beat 0 is bits [31:0]).
module cache_mem_bridge_line_word_mux
  import cache_mem_bridge_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [BEAT_W-1:0] idx,
  output logic [31:0]       word
);

  // Word slice of the line addressed by the beat index.
  assign word = line[{idx, 5'd0} +: 32];

endmodule

// File: rtl/cache_mem_bridge.sv
// Line-transfer engine between the data cache and a 32-bit memory bus.
// A dirty-victim writeback is always completed before the paired line fill
// is started; the fill data is assembled into fill_line beat by beat.
module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_line,
  output logic              wb_done,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic              fill_done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   wb_base;
  logic [ADDR_W-1:0]   fill_base;
  logic [LINE_W-1:0]   wb_line_q;
  logic                pend_fill;

  logic                beat_ack;
  logic                beat_last;
  logic [BEAT_W-1:0]   beat_nxt;
  logic [LINE_W-1:0]   mux_line;
  logic [BEAT_W-1:0]   mux_idx;
  logic [31:0]         mux_word;

  assign beat_ack  = mem_req & mem_ack;
  assign beat_last = (beat == BEAT_W'(BEATS - 1));
  assign beat_nxt  = beat + BEAT_W'(1);

  // In IDLE the first write word comes straight from the request port;
  // afterwards the next beat's word comes from the latched victim line.
  assign mux_line = (state == ST_IDLE) ? wb_line : wb_line_q;
  assign mux_idx  = (state == ST_IDLE) ? '0 : beat_nxt;

  cache_mem_bridge_line_word_mux u_word_mux (
    .line (mux_line),
    .idx  (mux_idx),
    .word (mux_word)
  );

  // Controller FSM; every bus and handshake output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      wb_done   <= 1'b0;
      fill_done <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fill_line <= '0;
    end else begin
      wb_done   <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (wb_req) begin
            wb_base   <= line_align(wb_addr);
            wb_line_q <= wb_line;
            pend_fill <= fill_req;
            fill_base <= line_align(fill_addr);
            state     <= ST_WB;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= line_align(wb_addr);
            mem_wdata <= mux_word;
          end else if (fill_req) begin
            fill_base <= line_align(fill_addr);
            pend_fill <= 1'b0;
            state     <= ST_FILL;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= line_align(fill_addr);
          end
        end

        ST_WB: begin
          if (beat_ack) begin
            if (beat_last) begin
              wb_done   <= 1'b1;
              beat      <= '0;
              mem_wdata <= '0;
              mem_we    <= 1'b0;
              if (pend_fill) begin
                // Request stays up: the fill's first read follows immediately.
                state    <= ST_FILL;
                mem_addr <= fill_base;
              end else begin
                state    <= ST_DONE;
                mem_req  <= 1'b0;
                mem_addr <= '0;
              end
            end else begin
              beat      <= beat_nxt;
              mem_addr  <= word_addr(wb_base, beat_nxt);
              mem_wdata <= mux_word;
            end
          end
        end

        ST_FILL: begin
          if (beat_ack) begin
            fill_line[{beat, 5'd0} +: 32] <= mem_rdata;
            if (beat_last) begin
              fill_done <= 1'b1;
              beat      <= '0;
              state     <= ST_DONE;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
            end else begin
              beat     <= beat_nxt;
              mem_addr <= word_addr(fill_base, beat_nxt);
            end
          end
        end

        ST_DONE: begin
          // Requests are ignored here so the client can drop its level request.
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: table of whole-line transfers plus
// hand-written sequences for held requests, mid-transfer reset and stray acks.
module tb_cache_mem_bridge;

  logic         clk;
  logic         rst;
  logic         wb_req;
  logic [31:0]  wb_addr;
  logic [127:0] wb_line;
  logic         wb_done;
  logic         fill_req;
  logic [31:0]  fill_addr;
  logic [127:0] fill_line;
  logic         fill_done;
  logic         busy;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ack;

  cache_mem_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .wb_req    (wb_req),
    .wb_addr   (wb_addr),
    .wb_line   (wb_line),
    .wb_done   (wb_done),
    .fill_req  (fill_req),
    .fill_addr (fill_addr),
    .fill_line (fill_line),
    .fill_done (fill_done),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- memory responder and bus monitor ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       blog [32];
  int          nbeats;
  int          wb_done_cnt;
  int          fill_done_cnt;
  int          wb_done_beats;
  int          last_done_cyc;
  bit          ack_tied;
  int          ack_wait;
  int          wcnt;
  bit          prev_pend;
  logic        prev_we;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;

  task automatic clear_log();
    nbeats        = 0;
    wb_done_cnt   = 0;
    fill_done_cnt = 0;
    wb_done_beats = -1;
    last_done_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (wb_done === 1'b1) begin
      wb_done_cnt++;
      wb_done_beats = nbeats;
      last_done_cyc = cyc;
    end
    if (fill_done === 1'b1) begin
      fill_done_cnt++;
      last_done_cyc = cyc;
    end
    if (prev_pend && !rst)
      check("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata},
            {1'b1, prev_we, prev_addr, prev_wdata});
    mem_rdata = 32'hA0 + ((mem_addr - 32'h1230) >> 2);
    if (ack_tied) begin
      mem_ack = 1'b1;
    end else begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
      if (mem_req === 1'b1) begin
        if (wcnt >= ack_wait) mem_ack = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
    if (mem_req === 1'b1 && mem_ack && nbeats < 32) begin
      blog[nbeats].we    = mem_we;
      blog[nbeats].addr  = mem_addr;
      blog[nbeats].wdata = mem_wdata;
      nbeats++;
    end
    prev_pend  = (mem_req === 1'b1) && !mem_ack && !rst;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy !== 1'b0 && t < 400) begin
      step();
      t++;
    end
    check({name, " idle"}, busy, 1'b0);
  endtask

  // ---------------- directed transfer table ----------------
  typedef struct {
    string        name;
    bit           wb;
    bit           fill;
    logic [31:0]  wb_addr;
    logic [31:0]  fill_addr;
    logic [127:0] line;
    int           wait_cyc;
    bit           tied;
    logic [31:0]  exp_wbase;
    logic [31:0]  exp_fbase;
    logic [127:0] exp_fill;
    int           exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"fill_1238", 1'b0, 1'b1, 32'h0, 32'h0000_1238, 128'h0, 0, 1'b1,
                32'h0, 32'h0000_1230, 128'h000000A3_000000A2_000000A1_000000A0, 5};
    vecs[1] = '{"wb_4000_wait2", 1'b1, 1'b0, 32'h0000_4000, 32'h0,
                128'h44444444_33333333_22222222_11111111, 2, 1'b0,
                32'h0000_4000, 32'h0, 128'h000000A3_000000A2_000000A1_000000A0, 13};
    vecs[2] = '{"wb_then_fill", 1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000,
                128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D, 0, 1'b1,
                32'h0000_2000, 32'h0000_3000, 128'h00000817_00000816_00000815_00000814, 9};
    vecs[3] = '{"fill_top_wait1", 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF4, 128'h0, 1, 1'b0,
                32'h0, 32'hFFFF_FFF0, 128'h3FFFFC13_3FFFFC12_3FFFFC11_3FFFFC10, 9};
    vecs[4] = '{"wb_top", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 1'b1,
                32'hFFFF_FFF0, 32'h0, 128'h3FFFFC13_3FFFFC12_3FFFFC11_3FFFFC10, 5};

    rst = 1'b1; wb_req = 1'b0; fill_req = 1'b0;
    wb_addr = '0; fill_addr = '0; wb_line = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    ack_tied = 1'b0; ack_wait = 0; wcnt = 0; prev_pend = 1'b0;
    clear_log();
    repeat (3) step();

    // Reset state
    check("rst mem_req",   mem_req,   1'b0);
    check("rst mem_we",    mem_we,    1'b0);
    check("rst wb_done",   wb_done,   1'b0);
    check("rst fill_done", fill_done, 1'b0);
    check("rst busy",      busy,      1'b0);
    check("rst mem_addr",  mem_addr,  32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst fill_line", fill_line, 128'h0);
    rst = 1'b0;
    step();

    // Table-driven transfers
    for (int i = 0; i < 5; i++) begin
      int req_cyc;
      int exp_w;
      int exp_r;
      int nw;
      clear_log();
      exp_w     = vecs[i].wb ? 4 : 0;
      exp_r     = vecs[i].fill ? 4 : 0;
      ack_tied  = vecs[i].tied;
      ack_wait  = vecs[i].wait_cyc;
      wb_req    = vecs[i].wb;
      fill_req  = vecs[i].fill;
      wb_addr   = vecs[i].wb_addr;
      fill_addr = vecs[i].fill_addr;
      wb_line   = vecs[i].line;
      req_cyc   = cyc;
      step();
      check({vecs[i].name, " accept busy"}, busy, 1'b1);
      wb_req   = 1'b0;
      fill_req = 1'b0;
      wait_idle(vecs[i].name);
      step();
      step();
      nw = 0;
      for (int k = 0; k < nbeats; k++) if (blog[k].we) nw++;
      check({vecs[i].name, " writes"}, nw, exp_w);
      check({vecs[i].name, " reads"}, nbeats - nw, exp_r);
      if (nbeats == exp_w + exp_r) begin
        for (int k = 0; k < nbeats; k++)
          check($sformatf("%s we[%0d]", vecs[i].name, k), blog[k].we, (k < exp_w));
        for (int k = 0; k < exp_w; k++) begin
          check($sformatf("%s waddr[%0d]", vecs[i].name, k), blog[k].addr,
                vecs[i].exp_wbase + 32'(4 * k));
          check($sformatf("%s wdata[%0d]", vecs[i].name, k), blog[k].wdata,
                vecs[i].line[32*k +: 32]);
        end
        for (int k = 0; k < exp_r; k++)
          check($sformatf("%s raddr[%0d]", vecs[i].name, k), blog[exp_w + k].addr,
                vecs[i].exp_fbase + 32'(4 * k));
      end
      check({vecs[i].name, " wb_done count"}, wb_done_cnt, vecs[i].wb ? 1 : 0);
      check({vecs[i].name, " fill_done count"}, fill_done_cnt, vecs[i].fill ? 1 : 0);
      if (vecs[i].wb)
        check({vecs[i].name, " wb_done after last write"}, wb_done_beats, 4);
      check({vecs[i].name, " latency"}, last_done_cyc - req_cyc, vecs[i].exp_lat);
      check({vecs[i].name, " fill_line"}, fill_line, vecs[i].exp_fill);
      check({vecs[i].name, " mem_req low"}, mem_req, 1'b0);
    end

    // Requests held high through DONE: re-accept only after the IDLE cycle
    begin
      bit found = 1'b0;
      clear_log();
      ack_tied  = 1'b1;
      fill_req  = 1'b1;
      fill_addr = 32'h0000_1238;
      for (int t = 0; t < 40 && !found; t++) begin
        step();
        if (fill_done === 1'b1) found = 1'b1;
      end
      check("held fill_done seen", found, 1'b1);
      check("held DONE busy", busy, 1'b1);
      check("held DONE mem_req", mem_req, 1'b0);
      step();
      check("held IDLE busy", busy, 1'b0);
      check("held IDLE mem_req", mem_req, 1'b0);
      step();
      check("held reaccept busy", busy, 1'b1);
      check("held reaccept mem_req", mem_req, 1'b1);
      check("held reaccept addr", mem_addr, 32'h0000_1230);
      fill_req = 1'b0;
      wait_idle("held");
      check("held fill_done count", fill_done_cnt, 2);
    end

    // Reset during beat 2 of a fill
    begin
      bit found = 1'b0;
      clear_log();
      ack_tied  = 1'b0;
      ack_wait  = 1;
      fill_req  = 1'b1;
      fill_addr = 32'h0000_1238;
      step();
      fill_req = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
        if (mem_req === 1'b1 && mem_addr === 32'h0000_1238) found = 1'b1;
        else step();
      end
      check("midrst reached beat2", found, 1'b1);
      rst = 1'b1;
      step();
      check("midrst mem_req", mem_req, 1'b0);
      check("midrst busy", busy, 1'b0);
      check("midrst fill_line", fill_line, 128'h0);
      check("midrst mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      repeat (4) step();
      check("midrst no fill_done", fill_done_cnt, 0);
      check("midrst still idle", busy, 1'b0);
      clear_log();
      ack_tied = 1'b1;
      fill_req = 1'b1;
      step();
      fill_req = 1'b0;
      wait_idle("refill");
      step();
      check("refill fill_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
      check("refill fill_done count", fill_done_cnt, 1);
    end

    // Stray mem_ack while idle
    clear_log();
    ack_tied = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step();
      check($sformatf("stray busy[%0d]", t), busy, 1'b0);
      check($sformatf("stray mem_req[%0d]", t), mem_req, 1'b0);
    end
    check("stray wb_done count", wb_done_cnt, 0);
    check("stray fill_done count", fill_done_cnt, 0);
    check("stray beats", nbeats, 0);
    ack_tied = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_bridge.md
Name: cache_mem_bridge

Overview:
- Line-transfer engine directly downstream of the data cache.
- Turns the cache's whole-line writeback (dirty eviction) and line-fill requests into sequences of 32-bit word transactions on the memory bus.
- Returns the assembled fill line as the cache's write_load_data.
- Serialises writeback-before-fill so a dirty victim always reaches memory before its replacement is fetched.

Parameters:
- LINE_BYTES, `CACHE_LINE_SIZE (16): bytes per cache line; must be a multiple of 4 and ≥8.
- ADDR_W, `MAX_BIT_POS+1 (32): address width.
- BEATS, LINE_BYTES/4 (4): derived localparam, words per line.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_req  in  1  writeback request (level); line in wb_line is dirty victim.
- wb_addr  in  ADDR_W  victim line address; low log2(LINE_BYTES) bits ignored.
- wb_line  in  LINE_BYTES*8  victim line data (cache write_back_data).
- wb_done  out  1  one-cycle pulse: all writeback beats acknowledged.
- fill_req  in  1  line fill request (level).
- fill_addr  in  ADDR_W  missing line address; low bits ignored.
- fill_line  out  LINE_BYTES*8  assembled fill data (cache write_load_data).
- fill_done  out  1  one-cycle pulse: fill_line complete and valid.
- busy  out  1  high whenever state ≠ IDLE.
- mem_req  out  1  word transaction request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address, always 4-byte aligned.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid when mem_ack=1 on a read.
- mem_ack  in  1  beat completes on any rising clk edge with mem_req && mem_ack.

Behaviour:
- Reset: sync active-high. On rst sampled high, state=IDLE, beat=0.
  - mem_req, mem_we, wb_done, fill_done and busy are 0.
  - mem_addr, mem_wdata and fill_line are 0.
  - Reset mid-transfer aborts with no done pulse; mem_req is low the cycle after.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - wb_req=1: latch line-aligned wb_addr and wb_line, latch pend_fill=fill_req and fill_addr, go to WB.
  - Else if fill_req=1: latch fill_addr, go to FILL.
  - Requests are sampled only in IDLE; changes while busy are ignored.
- WB:
  - Drive mem_req=1, mem_we=1, mem_addr=base+4*beat, mem_wdata=line[32*beat +: 32].
  - Byte order is little-endian: byte k of the line is at bits 8k.
  - On ack, beat++. mem_req stays high with the next beat's address the following cycle.
  - On ack of the last beat (beat==BEATS-1): wb_done=1 that cycle (registered pulse), beat=0.
    - Then go to FILL if pend_fill, else DONE.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr=fill_base+4*beat.
  - On ack, fill_line[32*beat +: 32] <= mem_rdata, beat++.
  - On last ack, fill_done pulses next cycle with fill_line fully valid. Go to DONE.
- DONE:
  - One cycle, requests ignored so the client can drop its level request. busy=1. Then IDLE.
- fill_line holds its value after fill_done until the first read beat of the next fill overwrites it.
- Outputs are registered. mem_* change only on clk edges and are stable while mem_req=1 && !mem_ack.
- mem_ack while mem_req=0 is ignored.
- Address arithmetic wraps modulo 2^ADDR_W. Beat offset never carries out of the line, since the base is aligned.
- Zero-wait memory (mem_ack tied high) finishes a BEATS-beat transfer in BEATS cycles.
  - Latency from request accept to done pulse is BEATS+1 cycles.

Decomposition:
- Shared package/config: LINE_BYTES (reuse `CACHE_LINE_SIZE), ADDR_W, BEATS, state encodings (ST_IDLE=0, ST_WB=1, ST_FILL=2, ST_DONE=3).
- Optional sub-module line_word_mux: beat index → 32-bit slice select of the line for mem_wdata. The rest stays in one module.

Test Plan:
- Fill only, mem_ack tied 1, fill_addr=0x0000_1238, memory word at 0x1230+4k = 0xA0+k:
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - fill_line=0x000000A3_000000A2_000000A1_000000A0.
  - fill_done pulses once, 5 cycles after accept.
- Writeback only, wb_addr=0x4000, wb_line=0x44444444_33333333_22222222_11111111, ack after 2 wait cycles per beat:
  - mem_we=1 and address/data held stable during waits.
  - Writes 0x11111111 at 0x4000 … 0x44444444 at 0x400C.
  - Single wb_done.
- wb_req and fill_req both high in IDLE (wb 0x2000, fill 0x3000):
  - 4 writes to 0x2000–0x200C, then wb_done, then 4 reads from 0x3000–0x300C, then fill_done. No read before the last write ack.
- Requests held high through DONE:
  - No second transfer starts until after DONE; re-accept happens only on the first IDLE cycle with req still high.
- rst asserted during beat 2 of a fill:
  - Next cycle mem_req=0, busy=0, fill_line=0.
  - No fill_done.
  - A new fill afterwards completes normally.
- fill_addr=0xFFFF_FFF4:
  - Aligned base 0xFFFF_FFF0, addresses 0xFFFF_FFF0…0xFFFF_FFFC, no carry out.
- Spurious mem_ack in IDLE: no state change, no done pulses.
